vliw_fwd_scoreboard: RTL and testbench

//  Parametrised cross-lane forwarding network for the N-lane VLIW integer pipeline.

---
 rtl/vliw_fwd_scoreboard_pkg.sv | 12 +
 rtl/vliw_fwd_match.sv | 50 +++++
 rtl/vliw_fwd_scoreboard.sv | 133 +++++++++++++
 tb/tb_vliw_fwd_scoreboard.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vliw_fwd_scoreboard_pkg.sv
// rtl/vliw_fwd_scoreboard_pkg.sv - shared forwarding select encoding and lane index type
package vliw_fwd_scoreboard_pkg;
   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_W   = 2'b01,
      FWD_M   = 2'b10
   } fwd_sel_t;

   // Widest bundle the lane index type can describe; matchers truncate to LSEL.
   localparam int MAX_LANES = 16;
   typedef logic [$clog2(MAX_LANES)-1:0] lane_idx_t;
endpackage

// File: rtl/vliw_fwd_match.sv
// rtl/vliw_fwd_match.sv - one operand's youngest-producer matcher across M and W lanes
module vliw_fwd_match
   import vliw_fwd_scoreboard_pkg::*;
#(
   parameter int NLANES = 4,
   parameter int AW     = 5,
   parameter int LSEL   = 2
) (
   input  logic [AW-1:0]        src,
   input  logic [NLANES*AW-1:0] rd_m,
   input  logic [NLANES-1:0]    reg_write_m,
   input  logic [NLANES-1:0]    load_m,
   input  logic [NLANES*AW-1:0] rd_w,
   input  logic [NLANES-1:0]    reg_write_w,
   output fwd_sel_t             sel,
   output logic [LSEL-1:0]      lane
);
   logic      hit_m, hit_w;
   lane_idx_t lane_m, lane_w;

   // Ascending scan so the highest matching lane overwrites earlier ones.
   always_comb begin
      hit_m  = 1'b0;
      hit_w  = 1'b0;
      lane_m = '0;
      lane_w = '0;
      for (int l = 0; l < NLANES; l++) begin
         if (src != '0 && reg_write_m[l] && !load_m[l] && rd_m[l*AW +: AW] == src) begin
            hit_m  = 1'b1;
            lane_m = lane_idx_t'(l);
         end
         if (src != '0 && reg_write_w[l] && rd_w[l*AW +: AW] == src) begin
            hit_w  = 1'b1;
            lane_w = lane_idx_t'(l);
         end
      end
   end

   always_comb begin
      sel  = FWD_REG;
      lane = '0;
      if (hit_m) begin
         sel  = FWD_M;
         lane = LSEL'(lane_m);
      end else if (hit_w) begin
         sel  = FWD_W;
         lane = LSEL'(lane_w);
      end
   end
endmodule

// File: rtl/vliw_fwd_scoreboard.sv
// rtl/vliw_fwd_scoreboard.sv - N-lane E/M/W destination tracking, cross-lane operand forwarding
// and load-use / same-bundle write-conflict detection.
module vliw_fwd_scoreboard
   import vliw_fwd_scoreboard_pkg::*;
#(
   parameter  int NLANES = 4,
   parameter  int XLEN   = 64,
   parameter  int AW     = 5,
   localparam int LSEL   = $clog2(NLANES)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NLANES*AW-1:0]   Rs1D,
   input  logic [NLANES*AW-1:0]   Rs2D,
   input  logic [NLANES*AW-1:0]   RdD,
   input  logic [NLANES-1:0]      RegWriteD,
   input  logic [NLANES-1:0]      LoadD,
   input  logic                   StallE,
   input  logic                   FlushE,
   input  logic                   StallM,
   input  logic                   FlushM,
   input  logic                   StallW,
   input  logic                   FlushW,
   input  logic [NLANES*XLEN-1:0] R1E,
   input  logic [NLANES*XLEN-1:0] R2E,
   input  logic [NLANES*XLEN-1:0] IFResultM,
   input  logic [NLANES*XLEN-1:0] ResultW,
   output logic [NLANES*2-1:0]    ForwardAE,
   output logic [NLANES*2-1:0]    ForwardBE,
   output logic [NLANES*LSEL-1:0] FwdLaneAE,
   output logic [NLANES*LSEL-1:0] FwdLaneBE,
   output logic [NLANES*XLEN-1:0] ForwardedSrcAE,
   output logic [NLANES*XLEN-1:0] ForwardedSrcBE,
   output logic                   LoadUseStallD,
   output logic                   WriteConflictD
);
   logic [NLANES*AW-1:0] Rs1E, Rs2E, RdE, RdM, RdW;
   logic [NLANES-1:0]    RegWriteE, LoadE, RegWriteM, LoadM, RegWriteW;

   // Stage registers: stall wins over flush, so a flush during a stall is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Rs1E <= '0; Rs2E <= '0; RdE <= '0; RegWriteE <= '0; LoadE <= '0;
      end else if (!StallE) begin
         if (FlushE) begin
            Rs1E <= '0; Rs2E <= '0; RdE <= '0; RegWriteE <= '0; LoadE <= '0;
         end else begin
            Rs1E <= Rs1D; Rs2E <= Rs2D; RdE <= RdD; RegWriteE <= RegWriteD; LoadE <= LoadD;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RdM <= '0; RegWriteM <= '0; LoadM <= '0;
      end else if (!StallM) begin
         if (FlushM) begin
            RdM <= '0; RegWriteM <= '0; LoadM <= '0;
         end else begin
            RdM <= RdE; RegWriteM <= RegWriteE; LoadM <= LoadE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RdW <= '0; RegWriteW <= '0;
      end else if (!StallW) begin
         if (FlushW) begin
            RdW <= '0; RegWriteW <= '0;
         end else begin
            RdW <= RdM; RegWriteW <= RegWriteM;
         end
      end
   end

   function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_t s, input logic [LSEL-1:0] ln,
                                              input logic [XLEN-1:0] r,
                                              input logic [NLANES*XLEN-1:0] m,
                                              input logic [NLANES*XLEN-1:0] w);
      case (s)
         FWD_M:   return m[ln*XLEN +: XLEN];
         FWD_W:   return w[ln*XLEN +: XLEN];
         default: return r;
      endcase
   endfunction

   fwd_sel_t        sel_a  [NLANES];
   fwd_sel_t        sel_b  [NLANES];
   logic [LSEL-1:0] lane_a [NLANES];
   logic [LSEL-1:0] lane_b [NLANES];

   for (genvar g = 0; g < NLANES; g++) begin : g_lane
      vliw_fwd_match #(.NLANES(NLANES), .AW(AW), .LSEL(LSEL)) u_match_a (
         .src(Rs1E[g*AW +: AW]), .rd_m(RdM), .reg_write_m(RegWriteM), .load_m(LoadM),
         .rd_w(RdW), .reg_write_w(RegWriteW), .sel(sel_a[g]), .lane(lane_a[g]));
      vliw_fwd_match #(.NLANES(NLANES), .AW(AW), .LSEL(LSEL)) u_match_b (
         .src(Rs2E[g*AW +: AW]), .rd_m(RdM), .reg_write_m(RegWriteM), .load_m(LoadM),
         .rd_w(RdW), .reg_write_w(RegWriteW), .sel(sel_b[g]), .lane(lane_b[g]));

      assign ForwardAE[g*2 +: 2]       = sel_a[g];
      assign ForwardBE[g*2 +: 2]       = sel_b[g];
      assign FwdLaneAE[g*LSEL +: LSEL] = lane_a[g];
      assign FwdLaneBE[g*LSEL +: LSEL] = lane_b[g];
      assign ForwardedSrcAE[g*XLEN +: XLEN] =
         fwd_mux(sel_a[g], lane_a[g], R1E[g*XLEN +: XLEN], IFResultM, ResultW);
      assign ForwardedSrcBE[g*XLEN +: XLEN] =
         fwd_mux(sel_b[g], lane_b[g], R2E[g*XLEN +: XLEN], IFResultM, ResultW);
   end

   // Load results only reach W, so any decode reader of an E-stage load must wait a cycle.
   always_comb begin
      LoadUseStallD  = 1'b0;
      WriteConflictD = 1'b0;
      for (int j = 0; j < NLANES; j++) begin
         for (int i = 0; i < NLANES; i++) begin
            if (RegWriteE[j] && LoadE[j]) begin
               if (Rs1D[i*AW +: AW] != '0 && Rs1D[i*AW +: AW] == RdE[j*AW +: AW])
                  LoadUseStallD = 1'b1;
               if (Rs2D[i*AW +: AW] != '0 && Rs2D[i*AW +: AW] == RdE[j*AW +: AW])
                  LoadUseStallD = 1'b1;
            end
         end
      end
      for (int i = 0; i < NLANES; i++) begin
         for (int j = i + 1; j < NLANES; j++) begin
            if (RegWriteD[i] && RegWriteD[j] && RdD[i*AW +: AW] != '0 &&
                RdD[i*AW +: AW] == RdD[j*AW +: AW])
               WriteConflictD = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_vliw_fwd_scoreboard.sv
// tb/tb_vliw_fwd_scoreboard.sv - directed scoreboard bench for vliw_fwd_scoreboard
module tb_vliw_fwd_scoreboard;
   localparam int NL = 4;
   localparam int XL = 64;
   localparam int AW = 5;
   localparam int LS = 2;

   localparam int K_FA = 0, K_FB = 1, K_LA = 2, K_LB = 3, K_SA = 4, K_SB = 5;
   localparam int K_LUS = 6, K_WC = 7, K_FAV = 8, K_FBV = 9;

   logic              clk, reset;
   logic [NL*AW-1:0]  Rs1D, Rs2D, RdD;
   logic [NL-1:0]     RegWriteD, LoadD;
   logic              StallE, FlushE, StallM, FlushM, StallW, FlushW;
   logic [NL*XL-1:0]  R1E, R2E, IFResultM, ResultW;
   logic [NL*2-1:0]   ForwardAE, ForwardBE;
   logic [NL*LS-1:0]  FwdLaneAE, FwdLaneBE;
   logic [NL*XL-1:0]  ForwardedSrcAE, ForwardedSrcBE;
   logic              LoadUseStallD, WriteConflictD;

   vliw_fwd_scoreboard #(.NLANES(NL), .XLEN(XL), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .LoadD(LoadD),
      .StallE(StallE), .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM),
      .StallW(StallW), .FlushW(FlushW),
      .R1E(R1E), .R2E(R2E), .IFResultM(IFResultM), .ResultW(ResultW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .FwdLaneAE(FwdLaneAE), .FwdLaneBE(FwdLaneBE),
      .ForwardedSrcAE(ForwardedSrcAE), .ForwardedSrcBE(ForwardedSrcBE),
      .LoadUseStallD(LoadUseStallD), .WriteConflictD(WriteConflictD));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      int          lane;
      logic [63:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   done  = 1'b0;

   function automatic string kname(int k);
      case (k)
         K_FA: return "ForwardAE";     K_FB: return "ForwardBE";
         K_LA: return "FwdLaneAE";     K_LB: return "FwdLaneBE";
         K_SA: return "ForwardedSrcAE"; K_SB: return "ForwardedSrcBE";
         K_LUS: return "LoadUseStallD"; K_WC: return "WriteConflictD";
         K_FAV: return "ForwardAE_all"; K_FBV: return "ForwardBE_all";
         default: return "unknown";
      endcase
   endfunction

   function automatic logic [63:0] actual(int k, int l);
      case (k)
         K_FA:  return 64'(ForwardAE[l*2 +: 2]);
         K_FB:  return 64'(ForwardBE[l*2 +: 2]);
         K_LA:  return 64'(FwdLaneAE[l*LS +: LS]);
         K_LB:  return 64'(FwdLaneBE[l*LS +: LS]);
         K_SA:  return ForwardedSrcAE[l*XL +: XL];
         K_SB:  return ForwardedSrcBE[l*XL +: XL];
         K_LUS: return 64'(LoadUseStallD);
         K_WC:  return 64'(WriteConflictD);
         K_FAV: return 64'(ForwardAE);
         K_FBV: return 64'(ForwardBE);
         default: return '1;
      endcase
   endfunction

   // Monitor: drains every expectation queued during the current half-cycle.
   initial begin
      exp_t e;
      logic [63:0] a;
      while (!done) begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            a = actual(e.kind, e.lane);
            n_cmp++;
            if (a !== e.v) begin
               n_bad++;
               $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", kname(e.kind), e.lane, a, e.v);
            end
         end
      end
   end

   task automatic expect_v(input int k, input int l, input logic [63:0] v);
      exp_t e;
      e.kind = k; e.lane = l; e.v = v;
      sb.push_back(e);
   endtask

   task automatic clear_d();
      Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = '0; LoadD = '0;
   endtask

   task automatic set_src(input int l, input int rs1, input int rs2);
      Rs1D[l*AW +: AW] = AW'(rs1);
      Rs2D[l*AW +: AW] = AW'(rs2);
   endtask

   task automatic set_wr(input int l, input int rd, input bit ld);
      RdD[l*AW +: AW] = AW'(rd);
      RegWriteD[l]    = 1'b1;
      LoadD[l]        = ld;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      clear_d();
      StallE = 0; FlushE = 0; StallM = 0; FlushM = 0; StallW = 0; FlushW = 0;
      R1E       = {64'h1003, 64'h1002, 64'h1001, 64'h1000};
      R2E       = {64'h2003, 64'h2002, 64'h2001, 64'h2000};
      IFResultM = {64'h3333, 64'h2222, 64'h00AA, 64'h1234};
      ResultW   = {64'h00BB, 64'h7777, 64'h9999, 64'h8888};
      step(); step();
      expect_v(K_FAV, 0, 64'h0); expect_v(K_FBV, 0, 64'h0);
      expect_v(K_LUS, 0, 64'h0); expect_v(K_SA, 2, 64'h1002);
      reset = 1'b1;

      // lane0 writes x5, lane2 reads it next bundle
      clear_d(); set_wr(0, 5, 0); step();
      clear_d(); set_src(2, 5, 0); step();
      expect_v(K_FA, 2, 64'h2); expect_v(K_LA, 2, 64'h0);
      expect_v(K_SA, 2, 64'h1234); expect_v(K_FB, 2, 64'h0);

      // x5 in W from lane3 and in M from lane1: M wins
      clear_d(); set_wr(3, 5, 0); step();
      clear_d(); set_wr(1, 5, 0); step();
      clear_d(); set_src(0, 0, 5); step();
      expect_v(K_FB, 0, 64'h2); expect_v(K_LB, 0, 64'h1); expect_v(K_SB, 0, 64'hAA);
      expect_v(K_FA, 0, 64'h0); expect_v(K_SA, 0, 64'h1000);

      // same-bundle write conflict, highest lane wins later
      clear_d(); set_wr(1, 7, 0); set_wr(3, 7, 0);
      expect_v(K_WC, 0, 64'h1);
      step();
      clear_d(); set_src(0, 7, 0);
      expect_v(K_WC, 0, 64'h0);
      step();
      expect_v(K_FA, 0, 64'h2); expect_v(K_LA, 0, 64'h3); expect_v(K_SA, 0, 64'h3333);

      // load-use: stall one cycle, bubble in E, then forward from W
      clear_d(); set_wr(1, 9, 1); step();
      clear_d(); set_src(0, 9, 0);
      expect_v(K_LUS, 0, 64'h1);
      FlushE = 1'b1; step(); FlushE = 1'b0;
      expect_v(K_LUS, 0, 64'h0);
      step();
      clear_d();
      expect_v(K_FA, 0, 64'h1); expect_v(K_LA, 0, 64'h1); expect_v(K_SA, 0, 64'h9999);

      // x0 never forwards
      clear_d(); set_wr(0, 0, 0); step();
      clear_d(); set_src(1, 0, 0); step();
      expect_v(K_FA, 1, 64'h0); expect_v(K_SA, 1, 64'h1001);

      // flush ignored while M is stalled
      clear_d(); set_wr(2, 11, 0); step();
      clear_d(); set_src(0, 11, 0); step();
      expect_v(K_FA, 0, 64'h2); expect_v(K_LA, 0, 64'h2); expect_v(K_SA, 0, 64'h2222);
      clear_d();
      StallE = 1'b1; StallM = 1'b1; FlushM = 1'b1; step();
      StallE = 1'b0; StallM = 1'b0; FlushM = 1'b0;
      expect_v(K_FA, 0, 64'h2); expect_v(K_LA, 0, 64'h2); expect_v(K_SA, 0, 64'h2222);

      // mid-stream async reset with pending producers
      clear_d(); set_wr(3, 12, 0); step();
      clear_d(); set_src(1, 12, 0); step();
      expect_v(K_FA, 1, 64'h2); expect_v(K_LA, 1, 64'h3);
      clear_d(); set_wr(0, 13, 1); step();
      clear_d(); set_src(0, 13, 0);
      expect_v(K_LUS, 0, 64'h1);
      @(negedge clk); #1;
      reset = 1'b0;
      expect_v(K_FAV, 0, 64'h0); expect_v(K_FBV, 0, 64'h0);
      expect_v(K_LUS, 0, 64'h0); expect_v(K_SA, 1, 64'h1001);
      @(posedge clk); #1;
      expect_v(K_FAV, 0, 64'h0); expect_v(K_LUS, 0, 64'h0);
      @(negedge clk); #1;
      reset = 1'b1;
      clear_d(); set_src(1, 12, 0); step();
      clear_d(); step();
      expect_v(K_FAV, 0, 64'h0); expect_v(K_FBV, 0, 64'h0); expect_v(K_SA, 1, 64'h1001);

      step();
      @(negedge clk); #1;
      done = 1'b1;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
